// File: rtl/signal_separation.sv
// Two-band splitter: a 10-tap boxcar low band and a delay-matched high band.
// The ADC clock is only used as a strobe that is sampled in the clk domain.
module signal_separation (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] adc_data,
  input  logic       adc_clk,
  output logic [7:0] low_freq_out,
  output logic [7:0] high_freq_out
);

  logic              d1_q, d2_q;
  logic              strobe;
  logic              upd_q;
  logic [7:0]        tap_q [10];
  logic [11:0]       sum_q, sum_d;
  logic [19:0]       prod;
  logic [7:0]        lp;
  logic [8:0]        ref_sum;
  logic [7:0]        ref_v;
  logic signed [9:0] diff;
  logic signed [9:0] hp_wide;
  logic [7:0]        hp;
  logic [7:0]        low_q, high_q;

  assign strobe = d1_q & ~d2_q;

  always_comb begin
    sum_d   = sum_q + {4'b0000, adc_data} - {4'b0000, tap_q[9]};
    // 205/2048 ~= 1/10; the product never exceeds 19 bits.
    prod    = {8'h00, sum_q} * 20'd205;
    lp      = prod[18:11];
    // Mean of taps 4 and 5 gives the 4.5-sample delay of the boxcar.
    ref_sum = {1'b0, tap_q[4]} + {1'b0, tap_q[5]};
    ref_v   = ref_sum[8:1];
    diff    = $signed({2'b00, ref_v}) - $signed({2'b00, lp});
    hp_wide = diff + 10'sd128;
    if (hp_wide[9]) begin
      hp = 8'h00;
    end else if (hp_wide[8]) begin
      hp = 8'hff;
    end else begin
      hp = hp_wide[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      d1_q   <= 1'b0;
      d2_q   <= 1'b0;
      upd_q  <= 1'b0;
      sum_q  <= '0;
      low_q  <= 8'h00;
      high_q <= 8'h80;
      for (int k = 0; k < 10; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      d1_q  <= adc_clk;
      d2_q  <= d1_q;
      upd_q <= strobe;
      if (strobe) begin
        tap_q[0] <= adc_data;
        for (int k = 1; k < 10; k++) begin
          tap_q[k] <= tap_q[k-1];
        end
        sum_q <= sum_d;
      end
      // Outputs follow one cycle later so they see the post-shift state.
      if (upd_q) begin
        low_q  <= lp;
        high_q <= hp;
      end
    end
  end

  assign low_freq_out  = low_q;
  assign high_freq_out = high_q;

endmodule

// File: tb/tb_signal_separation.sv
// Scoreboard bench for signal_separation: a reference model pushes expected
// band outputs per sample; they are popped when the outputs are due.
module tb_signal_separation;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] adc_data = 8'h00;
  logic       adc_clk = 1'b0;
  logic [7:0] low_freq_out, high_freq_out;

  always #5 clk = ~clk;

  signal_separation dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .adc_data      (adc_data),
    .adc_clk       (adc_clk),
    .low_freq_out  (low_freq_out),
    .high_freq_out (high_freq_out)
  );

  typedef struct {
    int lo;
    int hi;
  } exp_t;

  exp_t sb[$];
  int   m_tap[10];
  int   m_sum;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_lo = 0;
  int   last_hi = 128;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 10; k++) m_tap[k] = 0;
    m_sum   = 0;
    last_lo = 0;
    last_hi = 128;
    sb.delete();
  endfunction

  function automatic exp_t model_step(input int x);
    exp_t e;
    int   r, d;
    m_sum = m_sum + x - m_tap[9];
    for (int k = 9; k > 0; k--) m_tap[k] = m_tap[k-1];
    m_tap[0] = x;
    e.lo = (m_sum * 205) >>> 11;
    r    = (m_tap[4] + m_tap[5]) >>> 1;
    d    = r - e.lo + 128;
    e.hi = (d < 0) ? 0 : ((d > 255) ? 255 : d);
    return e;
  endfunction

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // One ADC sample: rise before E1, outputs valid after E3.
  task automatic send(input int x, input string tag);
    exp_t e;
    @(negedge clk);
    adc_data = 8'(x);
    adc_clk  = 1'b1;
    sb.push_back(model_step(x));
    @(negedge clk);
    @(negedge clk);
    adc_clk = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check_val({tag, "_lo"}, int'(low_freq_out), e.lo);
      check_val({tag, "_hi"}, int'(high_freq_out), e.hi);
      last_lo = e.lo;
      last_hi = e.hi;
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n   = 1'b1;
    adc_clk = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    check_val({tag, "_lo"}, int'(low_freq_out), 0);
    check_val({tag, "_hi"}, int'(high_freq_out), 128);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    model_reset();

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      adc_data = 8'($urandom_range(0, 255));
      adc_clk  = 1'($urandom_range(0, 1));
      check_val("rst_lo", int'(low_freq_out), 0);
      check_val("rst_hi", int'(high_freq_out), 128);
    end
    @(negedge clk);
    rst_n   = 1'b0;
    adc_clk = 1'b0;
    @(negedge clk);
    check_val("rel_lo", int'(low_freq_out), 0);
    check_val("rel_hi", int'(high_freq_out), 128);

    // DC input settles to 100 / 128.
    for (int i = 0; i < 12; i++) begin
      send(100, "dc");
      if (i >= 9) begin
        check_val("dc_settle_lo", int'(low_freq_out), 100);
        check_val("dc_settle_hi", int'(high_freq_out), 128);
      end
    end

    // Step 0 -> 255 from reset.
    pulse_reset("rst2");
    for (int i = 0; i < 10; i++) begin
      send(255, "step");
      if (i == 4) begin
        check_val("step5_lo", int'(low_freq_out), 127);
        check_val("step5_hi", int'(high_freq_out), 128);
      end
      if (i == 5) begin
        check_val("step6_lo", int'(low_freq_out), 153);
        check_val("step6_hi", int'(high_freq_out), 230);
      end
      if (i == 9) begin
        check_val("step10_lo", int'(low_freq_out), 255);
        check_val("step10_hi", int'(high_freq_out), 128);
      end
    end

    // Strobe gap: outputs hold while adc_clk stays low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      adc_data = 8'($urandom_range(0, 255));
      check_val("hold_lo", int'(low_freq_out), last_lo);
      check_val("hold_hi", int'(high_freq_out), last_hi);
    end

    // Pure fs/10 tone is nulled by the boxcar.
    pulse_reset("rst3");
    for (int i = 0; i < 30; i++) begin
      x = 128 + rnd(32.0 * $sin(2.0 * 3.14159265358979 * i / 10.0));
      send(x, "sine");
      if (i >= 10) begin
        check_val("sine_lo_band",
                  int'(low_freq_out >= 126 && low_freq_out <= 130), 1);
        check_val("sine_hi_band",
                  int'(high_freq_out >= 90 && high_freq_out <= 166), 1);
      end
    end

    // Mixed 1.67 MHz + 5 MHz input at 50 MS/s.
    pulse_reset("rst4");
    for (int i = 0; i < 60; i++) begin
      x = 80 + rnd(48.0 * $sin(2.0 * 3.14159265358979 * i / 30.0)
                   + 32.0 * $sin(2.0 * 3.14159265358979 * i / 10.0));
      send(x, "mix");
    end

    // Mid-stream reset discards history; DC re-settles after 10 strobes.
    pulse_reset("rst5");
    for (int i = 0; i < 10; i++) begin
      send(100, "dc2");
    end
    check_val("dc2_settle_lo", int'(low_freq_out), 100);
    check_val("dc2_settle_hi", int'(high_freq_out), 128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
